// File: rtl/inst_axi_rbridge.sv
// inst_axi_rbridge: bridges the instruction-fetch SRAM-like interface onto
// the AXI read channels (AR/R only). Writes are never issued; a write request
// is fetched as a read.
// Optional feature: define IBRIDGE_MULTI_OS_EN to allow two outstanding reads
// (default build allows one).
module inst_axi_rbridge #(
  parameter logic [3:0]  ARID_VAL         = 4'h0,
  parameter logic [31:0] RESET_VECTOR_CHK = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  // fetch side
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // status
  output logic        resp_err
);

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_BUSY = 1'b1;

`ifdef IBRIDGE_MULTI_OS_EN
  localparam logic [1:0] MAX_OS = 2'd2;
`else
  localparam logic [1:0] MAX_OS = 2'd1;
`endif

  logic [0:0]  state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [1:0]  os_q, os_d;
  logic        resp_err_q, resp_err_d;

  logic        addr_ok_s;
  logic        data_ok_s;
  logic        rready_s;

  // Inputs that the read-only bridge never looks at; collected so they are
  // visibly consumed. The reset vector is a bench-side reference only.
  logic        unused_inputs_s;
  assign unused_inputs_s = ^{RESET_VECTOR_CHK, inst_sram_wr, inst_sram_wstrb,
                             inst_sram_wdata, rid};

  // A new fetch is taken only with the AR channel free and credit available.
  assign addr_ok_s = !reset && inst_sram_req && (state_q == AR_IDLE) && (os_q < MAX_OS);
  // Accept R beats only while something is outstanding, so stale beats after
  // a reset are left unacknowledged.
  assign rready_s  = !reset && (os_q != 2'd0);
  assign data_ok_s = rvalid && rready_s && rlast;

  assign inst_sram_addr_ok = addr_ok_s;
  assign inst_sram_data_ok = data_ok_s;
  assign inst_sram_rdata   = rdata;

  assign arid    = ARID_VAL;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state_q == AR_BUSY);
  assign rready  = rready_s;
  assign resp_err = resp_err_q;

  // AR channel FSM and request latch: hold address/size stable until handshake.
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    case (state_q)
      AR_IDLE: begin
        if (addr_ok_s) begin
          state_d  = AR_BUSY;
          araddr_d = inst_sram_addr;
          arsize_d = {1'b0, inst_sram_size};
        end else begin
          state_d  = AR_IDLE;
        end
      end
      AR_BUSY: begin
        if (arready) begin
          state_d = AR_IDLE;
        end else begin
          state_d = AR_BUSY;
        end
      end
      default: begin
        state_d = AR_IDLE;
      end
    endcase
  end

  // Outstanding-read counter: accept adds one, returned data removes one.
  always_comb begin
    os_d = os_q;
    case ({addr_ok_s, data_ok_s})
      2'b10:   os_d = os_q + 2'd1;
      2'b01:   os_d = os_q - 2'd1;
      default: os_d = os_q;
    endcase
  end

  // Sticky error flag: any non-OKAY response on a returned fetch.
  always_comb begin
    if (data_ok_s && (rresp != 2'b00)) begin
      resp_err_d = 1'b1;
    end else begin
      resp_err_d = resp_err_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= AR_IDLE;
      araddr_q   <= 32'd0;
      arsize_q   <= 3'd0;
      os_q       <= 2'd0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      arsize_q   <= arsize_d;
      os_q       <= os_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_inst_axi_rbridge.sv
// Scoreboard bench for inst_axi_rbridge: stimulus pushes expected AR beats and
// fetch data into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_inst_axi_rbridge;

  localparam logic [31:0] RV   = 32'hbfc00000;
  localparam logic [3:0]  ARID = 4'h5;
`ifdef IBRIDGE_MULTI_OS_EN
  localparam int MAX_OS = 2;
`else
  localparam int MAX_OS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        resp_err;

  inst_axi_rbridge #(.ARID_VAL(ARID), .RESET_VECTOR_CHK(RV)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [34:0] ar_q[$];   // {arsize, araddr}
  logic [31:0] r_q[$];
  int          acc_cyc[$];
  int          dok_cyc[$];
  logic [34:0] mon_ar;
  logic [31:0] mon_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Cycle counter used to timestamp acceptances and data returns.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare AR handshakes and returned data against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (inst_sram_req && inst_sram_addr_ok) acc_cyc.push_back(cyc);
      if (arvalid && arready) begin
        if (ar_q.size() == 0) begin
          check("ar_unexpected", ar_q.size(), 1);
        end else begin
          mon_ar = ar_q.pop_front();
          check("araddr", araddr, mon_ar[31:0]);
          check("arsize", arsize, mon_ar[34:32]);
          check("ar_const", {arid, arlen, arburst, arlock, arcache, arprot},
                {ARID, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        end
      end
      if (inst_sram_data_ok) begin
        dok_cyc.push_back(cyc);
        if (r_q.size() == 0) begin
          check("dok_unexpected", r_q.size(), 1);
        end else begin
          mon_r = r_q.pop_front();
          check("rdata", inst_sram_rdata, mon_r);
        end
      end
    end
  end

  task automatic fetch_req(input logic [31:0] a, input logic [1:0] sz, input logic w,
                           input logic [31:0] d);
    bit done = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = a; inst_sram_size = sz;
    inst_sram_wr = w; inst_sram_wstrb = 4'hf; inst_sram_wdata = ~a;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (inst_sram_addr_ok) begin
        done = 1'b1;
        ar_q.push_back({1'b0, sz, a});
        r_q.push_back(d);
      end
      @(posedge clk); #1;
    end
    check("fetch_accepted", done, 1);
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] d, input logic [1:0] resp);
    bit done = 1'b0;
    rvalid = 1'b1; rdata = d; rresp = resp; rlast = 1'b1; rid = ARID;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (rready) done = 1'b1;
      @(posedge clk); #1;
    end
    check("r_accepted", done, 1);
    rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 80 && acc_cyc.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  int n_before;

  initial begin
    reset = 1'b1;
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
    inst_sram_wstrb = 4'd0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    // Reset state, with a request held high during reset.
    repeat (3) @(posedge clk);
    #1; inst_sram_req = 1'b1; inst_sram_addr = RV;
    @(negedge clk);
    check("rst_arvalid", arvalid, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arsize", arsize, 0);
    check("rst_rready", rready, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_addr_ok", inst_sram_addr_ok, 0);
    check("rst_data_ok", inst_sram_data_ok, 0);
    @(posedge clk); #1;
    reset = 1'b0; inst_sram_req = 1'b0;

    // Single fetch at the reset vector, minimum latency.
    arready = 1'b1;
    fetch_req(RV, 2'd2, 1'b0, 32'h3c080001);
    @(posedge clk); #1;
    r_beat(32'h3c080001, 2'b00);
    check("latency", (dok_cyc.size() > 0 && acc_cyc.size() > 0) ? dok_cyc[$] - acc_cyc[$] : -1, 2);
    check("single_dok_count", dok_cyc.size(), 1);

    // Write flag treated as a read, halfword size.
    fetch_req(32'h0000_1004, 2'd1, 1'b1, 32'h1234_5678);
    r_beat(32'h1234_5678, 2'b00);

    // AR backpressure: address stable, no new acceptance.
    arready = 1'b0;
    fetch_req(32'h0000_2000, 2'd2, 1'b0, 32'haaaa_5555);
    inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_3000; inst_sram_size = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_arvalid", arvalid, 1);
      check("bp_araddr", araddr, 32'h0000_2000);
      check("bp_addr_ok", inst_sram_addr_ok, 0);
      @(posedge clk); #1;
    end
    inst_sram_req = 1'b0;
    arready = 1'b1;
    @(posedge clk); #1;
    r_beat(32'haaaa_5555, 2'b00);

    // Outstanding limit: three back-to-back requests, R delayed 10 cycles.
    acc_cyc.delete(); dok_cyc.delete();
    fork
      begin
        fetch_req(32'h0000_0100, 2'd2, 1'b0, 32'h1111_0000);
        fetch_req(32'h0000_0104, 2'd2, 1'b0, 32'h2222_0000);
        fetch_req(32'h0000_0108, 2'd2, 1'b0, 32'h3333_0000);
      end
      begin
        wait_acc(1);
        repeat (10) begin @(posedge clk); #1; end
        r_beat(32'h1111_0000, 2'b00);
        wait_acc(2);
        r_beat(32'h2222_0000, 2'b00);
        wait_acc(3);
        r_beat(32'h3333_0000, 2'b00);
      end
    join
    check("os_acc_count", acc_cyc.size(), 3);
    check("os_dok_count", dok_cyc.size(), 3);
    n_before = 0;
    foreach (acc_cyc[i]) if (dok_cyc.size() > 0 && acc_cyc[i] < dok_cyc[0]) n_before++;
    check("os_acc_before_first_dok", n_before, MAX_OS);
    check("os_next_acc_cycle", (acc_cyc.size() > MAX_OS) ? acc_cyc[MAX_OS] : -1,
          (dok_cyc.size() > 0) ? dok_cyc[0] + 1 : -2);

    // Error response: data still returned, flag sticky.
    check("err_pre", resp_err, 0);
    fetch_req(32'h0000_4000, 2'd2, 1'b0, 32'hdead_beef);
    r_beat(32'hdead_beef, 2'b10);
    @(negedge clk);
    check("err_set", resp_err, 1);
    @(posedge clk); #1;
    fetch_req(32'h0000_4004, 2'd2, 1'b0, 32'h0bad_f00d);
    r_beat(32'h0bad_f00d, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("err_held", resp_err, 1);
      @(posedge clk); #1;
    end

    // Reset with one read outstanding; late R beat must be ignored.
    fetch_req(32'h0000_5000, 2'd2, 1'b0, 32'h5555_5555);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    r_q.delete();
    n_before = dok_cyc.size();
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hbad0_0000; rresp = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_rready", rready, 0);
      check("postrst_data_ok", inst_sram_data_ok, 0);
      check("postrst_resp_err", resp_err, 0);
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rdata = 32'd0;
    check("postrst_no_dok", dok_cyc.size(), n_before);

    // Fresh fetch after reset works normally.
    fetch_req(RV, 2'd2, 1'b0, 32'h2408_0002);
    r_beat(32'h2408_0002, 2'b00);
    @(posedge clk); #1;
    check("ar_q_drained", ar_q.size(), 0);
    check("r_q_drained", r_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit in case a bounded loop is defeated.
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/inst_axi_rbridge.md
INST_AXI_RBRIDGE -- requirements
Module: inst_axi_rbridge

Interface
REQ-001 Parameter ARID_VAL, default 4'h0, AXI ID driven on every read request.
REQ-002 Parameter RESET_VECTOR_CHK, default 32'hbfc00000, value of the first address expected after reset; used by the verification bench only, no RTL effect.
REQ-003 clk  input  1  clock; reset  input  1  synchronous, active-high reset.
REQ-004 inst_sram_req  input  1  fetch request; inst_sram_wr  input  1  write flag, expected 0.
REQ-005 inst_sram_size  input  2  log2 bytes; inst_sram_wstrb  input  4  ignored; inst_sram_addr  input  32  fetch address; inst_sram_wdata  input  32  ignored.
REQ-006 inst_sram_addr_ok  output  1  request accepted; inst_sram_data_ok  output  1  data return; inst_sram_rdata  output  32  instruction word.
REQ-007 arid  output  4; araddr  output  32; arlen  output  8; arsize  output  3; arburst  output  2; arlock  output  2; arcache  output  4; arprot  output  3; arvalid  output  1; arready  input  1.
REQ-008 rid  input  4; rdata  input  32; rresp  input  2; rlast  input  1; rvalid  input  1; rready  output  1.
REQ-009 resp_err  output  1  sticky flag, set by a non-OKAY read response.

Function
REQ-010 AR state machine SHALL have two states: AR_IDLE and AR_BUSY.
REQ-011 inst_sram_addr_ok SHALL be combinational: inst_sram_req && state==AR_IDLE && outstanding<MAX_OS.
REQ-012 On addr_ok: latch araddr<=inst_sram_addr and arsize<={1'b0,inst_sram_size}, then enter AR_BUSY with arvalid=1 on the next cycle.
REQ-013 In AR_BUSY, arvalid SHALL stay 1 and araddr/arsize SHALL stay stable until arvalid&&arready; on that cycle, return to AR_IDLE with arvalid=0 on the next cycle.
REQ-014 Constants: arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0, arid=ARID_VAL.
REQ-015 rready SHALL be 1 whenever outstanding>0, else 0.
REQ-016 inst_sram_data_ok=rvalid&&rready&&rlast; inst_sram_rdata=rdata, combinational passthrough.
REQ-017 Outstanding counter (2 bits): +1 on addr_ok, -1 on data_ok; both in the same cycle leave it unchanged.
REQ-018 Every accepted request SHALL produce exactly one data_ok, in acceptance order; the bridge SHALL NOT drop responses, since fetch-side cancel consumes them.
REQ-019 inst_sram_wr=1 SHALL be handled as a read; no AXI write channel exists.
REQ-020 resp_err SHALL set on data_ok with rresp!=2'b00 and clear only on reset; the data is still returned.
REQ-021 Minimum latency: req at cycle N -> arvalid at N+1 -> with arready=1 and rvalid at N+2, data_ok at N+2.

Reset
REQ-022 Reset SHALL force: state=AR_IDLE, arvalid=0, araddr=0, arsize=0, outstanding=0, rready=0, resp_err=0, addr_ok=0.
REQ-023 Reset mid-transaction SHALL abandon in-flight reads; rvalid arriving after reset with outstanding=0 SHALL be ignored (rready=0, no data_ok).

Configuration
REQ-024 Macro IBRIDGE_MULTI_OS_EN defined: MAX_OS=2, so a second request may be accepted while the first read's data is pending.
REQ-025 Macro IBRIDGE_MULTI_OS_EN undefined: MAX_OS=1, so addr_ok stays low until the pending data_ok; the counter never exceeds 1.

Verification
REQ-026 Single fetch: req addr=0xbfc00000, arready=1, rvalid one cycle later with rdata=0x3c080001 -> araddr=0xbfc00000, arsize=3'b010, one data_ok with rdata=0x3c080001.
REQ-027 AR backpressure: arready held 0 for 5 cycles -> arvalid stays 1, araddr stable, addr_ok=0 for a new req throughout.
REQ-028 Outstanding limit with macro defined: three back-to-back reqs, R delayed 10 cycles -> exactly 2 addr_ok, the third accepted only after the first data_ok.
REQ-029 Outstanding limit without the macro: same stimulus -> second addr_ok only after the first data_ok.
REQ-030 Error response: rresp=2'b10 -> data_ok asserted, resp_err=1 and held until reset.
REQ-031 Reset with one read outstanding, then rvalid=1 -> rready=0, no data_ok, outstanding=0.
